// File: rtl/mem_ls_unit.sv
// mem_ls_unit: load/store sequencer between the address mux and a word-wide
// synchronous data memory. Handles word, halfword and byte accesses, with a
// read-modify-write sequence for sub-word stores and sign/zero extension on loads.
// Optional build macro ALIGN_CHECK_EN: misaligned half/word accesses skip the
// memory entirely and complete immediately with addr_err raised alongside done.
module mem_ls_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        sext_q, sext_d;
  logic        err_q, err_d;
  logic        word_in;
  logic        misaligned;

  // Right-justify the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b10:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old memory word with the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = old_w;
    case (sz)
      2'b10: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign word_in = (size == 2'b00) || (size == 2'b11);

`ifdef ALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) && addr[0]) || (word_in && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Outputs decode straight from the state register, so reset clears them at once.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_wr    = (state_q == S_WRITE);
  assign addr_err  = done & err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rdata     = rdata_q;
  assign mem_wdata = mem_wr ? merge_lane(rbuf_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;

  // Next-state logic: request latching, read wait countdown, write and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    store_d = store_q;
    sext_d  = sext_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size;
          store_d = is_store;
          sext_d  = sign_ext;
          err_d   = misaligned;
          if (misaligned) begin
            state_d = S_DONE;
          end else if (is_store && word_in) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = 3'(MEM_LAT);
          end
        end
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rbuf_d = mem_rdata;
          if (store_q) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
            rdata_d = load_extend(mem_rdata, size_q, addr_q[1:0], sext_q);
          end
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset forces every output to its idle value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= 2'b00;
      store_q <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      store_q <= store_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_ls_unit.sv
// Testbench for mem_ls_unit: table of directed transactions, hand-written
// multi-cycle sequences (start while busy, reset mid-access, misaligned access)
// and randomized transactions checked against a lane-arithmetic reference model.
module tb_mem_ls_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        addr_err;

  logic [31:0] mem_word = 32'h0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  assign mem_rdata = mem_word;

  mem_ls_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .rdata(rdata),
    .busy(busy), .done(done), .addr_err(addr_err)
  );

  // Memory-side monitor: records every write strobe seen at a clock edge.
  always @(posedge clk) begin
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;
    int          lat;
    logic [31:0] rd;
    int          nwr;
    logic [31:0] wa;
    logic [31:0] wdo;
  } vec_t;

  // Reference model: expected outcome of one transaction from the lane rules.
  task automatic model(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                       input logic [31:0] prev, output int lat, output logic [31:0] rd,
                       output logic er, output int nwr, output logic [31:0] wa,
                       output logic [31:0] wdo);
    bit is_word;
    bit mis;
    int sh;
    logic [31:0] mask;
    is_word = (sz == 2'd0) || (sz == 2'd3);
    mis = 0;
`ifdef ALIGN_CHECK_EN
    mis = ((sz == 2'd1) && (a % 2 != 0)) || (is_word && (a % 4 != 0));
`endif
    if (sz == 2'd2)      begin sh = 8 * int'(a % 4);       mask = 32'hFF;       end
    else if (sz == 2'd1) begin sh = 16 * int'((a / 2) % 2); mask = 32'hFFFF;     end
    else                 begin sh = 0;                      mask = 32'hFFFFFFFF; end
    rd = prev; er = 0; nwr = 0; wa = a - (a % 4); wdo = 32'h0;
    if (mis) begin
      lat = 1; er = 1;
    end else if (st && is_word) begin
      lat = 2; nwr = 1; wdo = wd;
    end else if (st) begin
      lat = LAT + 2; nwr = 1;
      wdo = (mw & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      lat = LAT + 1;
      rd = (mw >> sh) & mask;
      if (sx && ((rd & ((mask >> 1) + 1)) != 0)) rd = rd | ~mask;
    end
  endtask

  // Issue one request and observe the transaction until done (bounded wait).
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nwr, output logic [31:0] wa, output logic [31:0] wdo,
                        output logic [31:0] ma, output logic busy_ok);
    int w0;
    lat = -1; rd = 32'h0; er = 1'b0; ma = 32'h0; busy_ok = 1'b1;
    @(negedge clk);
    mem_word = mw; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    start = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k; rd = rdata; er = addr_err; ma = mem_addr;
        break;
      end
    end
    nwr = wr_cnt - w0;
    wa  = last_wa;
    wdo = last_wd;
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  vec_t        vecs[9];
  int          lat, e_lat, nwr, e_nwr, w0;
  logic [31:0] rd, e_rd, wa, e_wa, wdo, e_wdo, ma;
  logic        er, e_er, bok;

  initial begin
    reset_n = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0;

    vecs[0] = '{0, 2'd0, 0, 32'h10, 32'h0,        32'hDEADBEEF, LAT+1, 32'hDEADBEEF, 0, 32'h0,  32'h0};
    vecs[1] = '{0, 2'd2, 1, 32'h13, 32'h0,        32'h80112233, LAT+1, 32'hFFFFFF80, 0, 32'h0,  32'h0};
    vecs[2] = '{0, 2'd2, 0, 32'h13, 32'h0,        32'h80112233, LAT+1, 32'h00000080, 0, 32'h0,  32'h0};
    vecs[3] = '{1, 2'd1, 0, 32'h22, 32'h0000ABCD, 32'h11223344, LAT+2, 32'h00000080, 1, 32'h20, 32'hABCD3344};
    vecs[4] = '{1, 2'd0, 0, 32'h40, 32'h12345678, 32'h0,        2,     32'h00000080, 1, 32'h40, 32'h12345678};
    vecs[5] = '{0, 2'd1, 1, 32'h16, 32'h0,        32'h80017FFF, LAT+1, 32'hFFFF8001, 0, 32'h0,  32'h0};
    vecs[6] = '{1, 2'd2, 0, 32'h05, 32'hAABBCCDD, 32'h11223344, LAT+2, 32'hFFFF8001, 1, 32'h04, 32'h1122DD44};
    vecs[7] = '{0, 2'd1, 1, 32'h08, 32'h0,        32'h12348765, LAT+1, 32'hFFFF8765, 0, 32'h0,  32'h0};
    vecs[8] = '{0, 2'd3, 0, 32'h0C, 32'h0,        32'hCAFEF00D, LAT+1, 32'hCAFEF00D, 0, 32'h0,  32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd, vecs[i].mw,
             lat, rd, er, nwr, wa, wdo, ma, bok);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(vecs[i].nwr));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'd0);
      chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
      chk($sformatf("vec%0d_mem_addr", i), ma, vecs[i].a & 32'hFFFFFFFC);
      if (vecs[i].nwr == 1) begin
        chk($sformatf("vec%0d_wa", i), wa, vecs[i].wa);
        chk($sformatf("vec%0d_wd", i), wdo, vecs[i].wdo);
      end
      ref_rdata = vecs[i].rd;
    end

    // Start pulsed while busy with a word store is ignored
    @(negedge clk);
    is_store = 1'b1; size = 2'd0; addr = 32'h40; wdata = 32'h12345678; start = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("bsy_c1_mem_wr", 32'(mem_wr), 32'd1);
    chk("bsy_c1_wdata", mem_wdata, 32'h12345678);
    chk("bsy_c1_addr", mem_addr, 32'h40);
    is_store = 1'b0; addr = 32'h80; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("bsy_c2_done", 32'(done), 32'd1);
    chk("bsy_c2_busy", 32'(busy), 32'd1);
    chk("bsy_c2_mem_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    chk("bsy_c3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bsy_c4_busy", 32'(busy), 32'd0);
    chk("bsy_nwr", 32'(wr_cnt - w0), 32'd1);

    // Misaligned word load
    run_op(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 32'h55667788, lat, rd, er, nwr, wa, wdo, ma, bok);
`ifdef ALIGN_CHECK_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, ref_rdata);
`else
    chk("mis_lat", 32'(lat), 32'(LAT + 1));
    chk("mis_err", 32'(er), 32'd0);
    chk("mis_rdata", rd, 32'h55667788);
    chk("mis_mem_addr", ma, 32'h40);
    ref_rdata = 32'h55667788;
`endif
    chk("mis_nwr", 32'(nwr), 32'd0);

    // Reset during the read phase of a byte store
    @(negedge clk);
    is_store = 1'b1; size = 2'd2; addr = 32'h07; wdata = 32'h000000EE; mem_word = 32'h0;
    start = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rmid_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_mem_wr", 32'(mem_wr), 32'd0);
    chk("rmid_done", 32'(done), 32'd0);
    chk("rmid_rdata", rdata, 32'h0);
    chk("rmid_mem_addr", mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rmid_no_write", 32'(wr_cnt - w0), 32'd0);
    ref_rdata = 32'h0;
    run_op(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hBEEF0001, lat, rd, er, nwr, wa, wdo, ma, bok);
    chk("rmid_after_lat", 32'(lat), 32'(LAT + 1));
    chk("rmid_after_rdata", rd, 32'h0000BEEF);
    ref_rdata = 32'h0000BEEF;

    // Randomized transactions against the reference model
    for (int n = 0; n < 150; n++) begin
      logic        st, sx;
      logic [1:0]  sz;
      logic [31:0] a, wd, mw;
      st = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      wd = $urandom;
      mw = $urandom;
      model(st, sz, sx, a, wd, mw, ref_rdata, e_lat, e_rd, e_er, e_nwr, e_wa, e_wdo);
      run_op(st, sz, sx, a, wd, mw, lat, rd, er, nwr, wa, wdo, ma, bok);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_nwr", n), 32'(nwr), 32'(e_nwr));
      chk($sformatf("rnd%0d_busy", n), 32'(bok), 32'd1);
      if (e_nwr == 1) begin
        chk($sformatf("rnd%0d_wa", n), wa, e_wa);
        chk($sformatf("rnd%0d_wd", n), wdo, e_wdo);
      end
      ref_rdata = e_rd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
